// File: rtl/aes_key_expander_pkg.sv
// Shared constants, FSM encoding and helpers for the iterative AES key schedule.
package aes_key_expander_pkg;

    localparam logic [1:0] AES_128_BIT_KEY = 2'h0;
    localparam logic [1:0] AES_192_BIT_KEY = 2'h1;
    localparam logic [1:0] AES_256_BIT_KEY = 2'h2;

    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES192_ROUNDS = 4'hc;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

    localparam int KEY_MEM_WORDS = 60;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        LOAD = 2'h1,
        GEN  = 2'h2,
        DONE = 2'h3
    } ks_state_e;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Unsupported encoding 3 falls back to the 128-bit schedule.
    function automatic logic [3:0] rounds_for(input logic [1:0] kl);
        case (kl)
            AES_192_BIT_KEY: return AES192_ROUNDS;
            AES_256_BIT_KEY: return AES256_ROUNDS;
            default:         return AES128_ROUNDS;
        endcase
    endfunction

    function automatic logic [3:0] nk_for(input logic [1:0] kl);
        case (kl)
            AES_192_BIT_KEY: return 4'd6;
            AES_256_BIT_KEY: return 4'd8;
            default:         return 4'd4;
        endcase
    endfunction

    function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] idx);
        logic [255:0] sh;
        sh = k << {idx, 5'b0};
        return sh[255:224];
    endfunction

endpackage

// File: rtl/aes_key_mem_array.sv
// 60x32 round-key storage: bulk key load, one-word write port, 128-bit row read.
module aes_key_mem_array
    import aes_key_expander_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_en_i,
    input  logic [3:0]   load_nk_i,
    input  logic [255:0] load_key_i,
    input  logic         we_i,
    input  logic [5:0]   waddr_i,
    input  logic [31:0]  wdata_i,
    input  logic [3:0]   raddr_i,
    output logic [127:0] rdata_o
);

    logic [31:0] mem_q [KEY_MEM_WORDS];
    logic [5:0]  base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < KEY_MEM_WORDS; k++) begin
                mem_q[k] <= '0;
            end
        end else if (load_en_i) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(load_nk_i)) begin
                    mem_q[k] <= key_word(load_key_i, 3'(k));
                end
            end
        end else if (we_i && (int'(waddr_i) < KEY_MEM_WORDS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Row 15 has no backing words and reads as zero.
    always_comb begin
        base    = {raddr_i, 2'b00};
        rdata_o = '0;
        if (raddr_i != 4'hf) begin
            rdata_o = {mem_q[base], mem_q[base + 6'd1], mem_q[base + 6'd2], mem_q[base + 6'd3]};
        end
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key expansion, one schedule word per cycle,
// with SubWord served by an external shared S-box.
module aes_key_expander
    import aes_key_expander_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [1:0]   keylen,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    ks_state_e          state_q, state_d;
    logic [255:0]       key_q, key_d;
    logic [1:0]         keylen_q, keylen_d;
    logic               ready_q, ready_d;
    logic [7:0]         rcon_q, rcon_d;
    logic [5:0]         i_q, i_d;
    logic [2:0]         mod_q, mod_d;
    logic [7:0][31:0]   win_q, win_d;

    logic [3:0]         nk;
    logic [5:0]         last_idx;
    logic [2:0]         far_idx;
    logic               rot_sub;
    logic               plain_sub;
    logic [31:0]        prev_word;
    logic [31:0]        tmp_word;
    logic [31:0]        new_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            keylen_q <= '0;
            ready_q  <= 1'b0;
            rcon_q   <= 8'h01;
            i_q      <= '0;
            mod_q    <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            ready_q  <= ready_d;
            rcon_q   <= rcon_d;
            i_q      <= i_d;
            mod_q    <= mod_d;
            win_q    <= win_d;
        end
    end

    // Window slot 0 is w[i-1]; slot Nk-1 is w[i-Nk].
    always_comb begin
        nk        = nk_for(keylen_q);
        last_idx  = {rounds_for(keylen_q), 2'b11};
        far_idx   = 3'(nk - 4'd1);
        prev_word = win_q[0];
        rot_sub   = (state_q == GEN) && (mod_q == 3'd0);
        plain_sub = (state_q == GEN) && (nk == 4'd8) && (mod_q == 3'd4);

        sboxw    = 32'h0;
        tmp_word = prev_word;
        if (rot_sub) begin
            sboxw    = {prev_word[23:0], prev_word[31:24]};
            tmp_word = new_sboxw ^ {rcon_q, 24'h0};
        end else if (plain_sub) begin
            sboxw    = prev_word;
            tmp_word = new_sboxw;
        end
        new_word = win_q[far_idx] ^ tmp_word;
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        keylen_d = keylen_q;
        ready_d  = ready_q;
        rcon_d   = rcon_q;
        i_d      = i_q;
        mod_d    = mod_q;
        win_d    = win_q;

        case (state_q)
            IDLE: begin
                if (init) begin
                    key_d    = key;
                    keylen_d = (keylen == 2'h3) ? AES_128_BIT_KEY : keylen;
                    ready_d  = 1'b0;
                    rcon_d   = 8'h01;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(nk)) begin
                        win_d[j] = key_word(key_q, 3'(int'(nk) - 1 - j));
                    end else begin
                        win_d[j] = '0;
                    end
                end
                i_d     = {2'b00, nk};
                mod_d   = 3'd0;
                state_d = GEN;
            end
            GEN: begin
                win_d = {win_q[6:0], new_word};
                i_d   = i_q + 6'd1;
                mod_d = (mod_q == far_idx) ? 3'd0 : mod_q + 3'd1;
                if (rot_sub) begin
                    rcon_d = gm2(rcon_q);
                end
                if (i_q == last_idx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    aes_key_mem_array u_mem (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en_i  (state_q == LOAD),
        .load_nk_i  (nk),
        .load_key_i (key_q),
        .we_i       (state_q == GEN),
        .waddr_i    (i_q),
        .wdata_i    (new_word),
        .raddr_i    (round),
        .rdata_o    (round_key)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander with a behavioural S-box and key-schedule model.
module tb_aes_key_expander;

    localparam logic [255:0] K128 = 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_00000000_00000000_00000000_00000000;
    localparam logic [255:0] K192 = 256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b_00000000_00000000;
    localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    logic         clk;
    logic         reset_n;
    logic         init;
    logic [1:0]   keylen;
    logic [255:0] key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sboxTab [256];
    logic [7:0]   rconTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] expQ [$];

    aes_key_expander dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .keylen    (keylen),
        .key       (key),
        .round     (round),
        .round_key (round_key),
        .ready     (ready),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign new_sboxw = {sboxTab[sboxw[31:24]], sboxTab[sboxw[23:16]],
                        sboxTab[sboxw[15:8]],  sboxTab[sboxw[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h0; aa = a; bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sboxCalc(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int n = 0; n < 254; n++) r = gmul(r, x);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    task automatic modelPush(input logic [1:0] kl, input logic [255:0] k);
        int nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subWord({t[23:0], t[31:24]}) ^ {rconTab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4) t = subWord(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) expQ.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    endtask

    task automatic startExpansion(input logic [1:0] kl, input logic [255:0] k);
        @(posedge clk); #1;
        keylen = kl; key = k; init = 1'b1;
        modelPush(kl, k);
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic waitReady(input int startCycle, output int cycles, output int sbCount);
        cycles = startCycle;
        sbCount = 0;
        forever begin
            @(posedge clk); #1;
            cycles++;
            if (sboxw !== 32'h0) sbCount++;
            if (ready === 1'b1) break;
            if (cycles >= 200) begin
                checks++; errors++;
                $display("[TB] FAIL ready_timeout: ready not seen after %0d cycles", cycles);
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", ready); end
        checks++; if (sboxw !== 32'h0) begin errors++; $display("[TB] FAIL reset_sboxw got %h want 0", sboxw); end
        round = 4'd0; #1;
        checks++; if (round_key !== 128'h0) begin errors++; $display("[TB] FAIL reset_rk0 got %h want 0", round_key); end
        round = 4'd14; #1;
        checks++; if (round_key !== 128'h0) begin errors++; $display("[TB] FAIL reset_rk14 got %h want 0", round_key); end
    endtask

    task automatic test_aes128();
        int cyc, sb;
        logic [127:0] exp;
        startExpansion(2'd0, K128);
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 43) begin errors++; $display("[TB] FAIL aes128_latency got %0d want 43", cyc); end
        checks++; if (sb !== 10) begin errors++; $display("[TB] FAIL aes128_subword_cycles got %0d want 10", sb); end
        for (int r = 0; r <= 10; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL aes128_rk%0d got %h want %h", r, round_key, exp); end
        end
        round = 4'd1; #1;
        checks++; if (round_key !== 128'ha0fafe17_88542cb1_23a33939_2a6c7605) begin errors++; $display("[TB] FAIL aes128_fips_rk1 got %h", round_key); end
        round = 4'd10; #1;
        checks++; if (round_key !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6) begin errors++; $display("[TB] FAIL aes128_fips_rk10 got %h", round_key); end
        round = 4'd15; #1;
        checks++; if (round_key !== 128'h0) begin errors++; $display("[TB] FAIL round15 got %h want 0", round_key); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL aes128_ready_hold got %b want 1", ready); end
    endtask

    task automatic test_aes192();
        int cyc, sb;
        logic [127:0] exp;
        startExpansion(2'd1, K192);
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 49) begin errors++; $display("[TB] FAIL aes192_latency got %0d want 49", cyc); end
        for (int r = 0; r <= 12; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL aes192_rk%0d got %h want %h", r, round_key, exp); end
        end
        round = 4'd12; #1;
        checks++; if (round_key !== 128'he98ba06f_448c773c_8ecc7204_01002202) begin errors++; $display("[TB] FAIL aes192_fips_rk12 got %h", round_key); end
    endtask

    task automatic test_aes256();
        int cyc, sb, expSb;
        logic [127:0] exp;
        expSb = 0;
        for (int i = 8; i < 60; i++) if ((i % 8 == 0) || (i % 8 == 4)) expSb++;
        startExpansion(2'd2, K256);
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 55) begin errors++; $display("[TB] FAIL aes256_latency got %0d want 55", cyc); end
        checks++; if (sb !== expSb) begin errors++; $display("[TB] FAIL aes256_subword_cycles got %0d want %0d", sb, expSb); end
        for (int r = 0; r <= 14; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL aes256_rk%0d got %h want %h", r, round_key, exp); end
        end
        round = 4'd14; #1;
        checks++; if (round_key !== 128'hfe4890d1_e6188d0b_046df344_706c631e) begin errors++; $display("[TB] FAIL aes256_fips_rk14 got %h", round_key); end
    endtask

    task automatic test_keylen3();
        int cyc, sb;
        logic [127:0] exp;
        startExpansion(2'd3, K128);
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 43) begin errors++; $display("[TB] FAIL keylen3_latency got %0d want 43", cyc); end
        for (int r = 0; r <= 10; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL keylen3_rk%0d got %h want %h", r, round_key, exp); end
        end
    endtask

    task automatic test_ignored_init();
        int cyc, sb;
        logic [127:0] exp;
        startExpansion(2'd0, K128);
        repeat (9) @(posedge clk);
        #1;
        keylen = 2'd2; key = K256; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        waitReady(11, cyc, sb);
        checks++; if (cyc !== 43) begin errors++; $display("[TB] FAIL ignored_init_latency got %0d want 43", cyc); end
        for (int r = 0; r <= 10; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL ignored_init_rk%0d got %h want %h", r, round_key, exp); end
        end
        startExpansion(2'd1, K192);
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 49) begin errors++; $display("[TB] FAIL regen192_latency got %0d want 49", cyc); end
        for (int r = 0; r <= 12; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL regen192_rk%0d got %h want %h", r, round_key, exp); end
        end
    endtask

    task automatic test_mid_reset();
        int cyc, sb;
        logic [127:0] exp;
        @(posedge clk); #1;
        keylen = 2'd2; key = K256; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ready got %b want 0", ready); end
        checks++; if (sboxw !== 32'h0) begin errors++; $display("[TB] FAIL midreset_sboxw got %h want 0", sboxw); end
        for (int r = 0; r <= 14; r += 7) begin
            round = 4'(r); #1;
            checks++; if (round_key !== 128'h0) begin errors++; $display("[TB] FAIL midreset_rk%0d got %h want 0", r, round_key); end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        startExpansion(2'd0, K128);
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 43) begin errors++; $display("[TB] FAIL postreset_latency got %0d want 43", cyc); end
        for (int r = 0; r <= 10; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL postreset_rk%0d got %h want %h", r, round_key, exp); end
        end
        round = 4'd10; #1;
        checks++; if (round_key !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6) begin errors++; $display("[TB] FAIL postreset_fips_rk10 got %h", round_key); end
    endtask

    task automatic test_back_to_back();
        int cyc, sb;
        logic [127:0] exp;
        @(posedge clk); #1;
        keylen = 2'd0; key = K128; init = 1'b1;
        modelPush(2'd0, K128);
        @(posedge clk); #1;
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 43) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 43", cyc); end
        @(posedge clk); #1;
        init = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_pulse got %b want 0", ready); end
        waitReady(1, cyc, sb);
        checks++; if (cyc !== 43) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 43", cyc); end
        for (int r = 0; r <= 10; r++) begin
            round = 4'(r); #1;
            exp = expQ.pop_front();
            checks++; if (round_key !== exp) begin errors++; $display("[TB] FAIL b2b_rk%0d got %h want %h", r, round_key, exp); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        init    = 1'b0;
        keylen  = 2'd0;
        key     = '0;
        round   = 4'd0;
        for (int v = 0; v < 256; v++) sboxTab[v] = sboxCalc(8'(v));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        $display("[TB] AES-128 expansion");
        test_aes128();
        $display("[TB] AES-192 expansion");
        test_aes192();
        $display("[TB] AES-256 expansion");
        test_aes256();
        $display("[TB] keylen 3 as 128");
        test_keylen3();
        $display("[TB] init during expansion ignored");
        test_ignored_init();
        $display("[TB] reset during expansion");
        test_mid_reset();
        $display("[TB] init held across DONE");
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
